sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, next generation of the team's 4x8 FIFO. Adds configurable data width and depth, full-depth occupancy (all DEPTH entries usable), occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, synchronous flush and an optional first-word-fall-through (FWFT) read mode. Used as the generic buffering element between producer/consumer blocks in the same clock domain.

---
 rtl/sync_fifo_param.sv | 105 ++++++++++
 tb/tb_sync_fifo_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// error flags, synchronous flush and optional first-word-fall-through output.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              rd_acc, wr_acc;

    assign full         = (cnt_q == CW'(DEPTH));
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= CW'(AF_THRESH));
    assign almost_empty = (cnt_q <= CW'(AE_THRESH));
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A read on a full FIFO frees the slot the concurrent write lands in.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            dout_d   = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_acc && !rd_acc) cnt_d = cnt_q + CW'(1);
            else if (rd_acc && !wr_acc) cnt_d = cnt_q - CW'(1);
            if (FWFT == 0 && rd_acc) dout_d = mem_q[rd_ptr_q];
            if (wr_en && !wr_acc) ovf_d = 1'b1;
            if (rd_en && empty) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!flush && wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? dout_q : mem_q[rd_ptr_q];
        end else begin : g_std
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard and an FWFT instance share stimulus and
// are compared against a queue-based model, plus directed vectors and sequences.
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rstn, flush, wr_en, rd_en;
    logic [7:0] data_in;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] s_cnt, f_cnt;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_unf;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(0)) u_dut (
        .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(1)) u_fwft (
        .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endfunction

    // Queue semantics: pop happens before push, so a full FIFO takes a write
    // whenever a read is accepted in the same cycle.
    function automatic void model_edge(input logic f, input logic w, input logic [7:0] d, input logic r);
        bit ra, wa;
        if (f) begin
            model_reset();
            return;
        end
        ra = r && (q.size() > 0);
        wa = w && (q.size() < 8 || ra);
        if (w && !wa) m_ovf = 1'b1;
        if (r && q.size() == 0) m_unf = 1'b1;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(d);
    endfunction

    function automatic void check_all();
        int c = q.size();
        chk("count",        32'(s_cnt),   32'(c));
        chk("full",         32'(s_full),  32'(c == 8));
        chk("empty",        32'(s_empty), 32'(c == 0));
        chk("almost_full",  32'(s_af),    32'(c >= 7));
        chk("almost_empty", 32'(s_ae),    32'(c <= 1));
        chk("overflow",     32'(s_ovf),   32'(m_ovf));
        chk("underflow",    32'(s_unf),   32'(m_unf));
        chk("data_out",     32'(s_dout),  32'(m_dout));
        chk("fwft_count",   32'(f_cnt),   32'(c));
        chk("fwft_ovf_unf", {f_ovf, f_unf}, {m_ovf, m_unf});
        if (c > 0) chk("fwft_head", 32'(f_dout), 32'(q[0]));
    endfunction

    task automatic step(input logic f, input logic w, input logic [7:0] d, input logic r);
        @(negedge clk);
        flush = f; wr_en = w; data_in = d; rd_en = r;
        @(posedge clk);
        model_edge(f, w, d, r);
        #1;
        check_all();
    endtask

    typedef struct {
        logic       f, w, r;
        logic [7:0] d;
        int         cnt;
        logic [7:0] dout;
        logic       full, empty, ovf, unf;
    } vec_t;
    vec_t tbl[18];

    initial begin
        rstn = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        model_reset();

        // Expected values for the fill / overflow / drain / underflow run.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b0, 8'(i + 1), i + 1, 8'h00, (i == 7), 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h09, 8, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++)
            tbl[9 + i] = '{1'b0, 1'b0, 1'b1, 8'h00, 7 - i, 8'(i + 1), 1'b0, (i == 7), 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h08, 1'b0, 1'b1, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(s_cnt), 0);
        chk("rst_flags", {s_full, s_empty, s_af, s_ae, s_ovf, s_unf}, 32'b010100);
        chk("rst_dout",  32'(s_dout), 0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].f, tbl[i].w, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d_count", i), 32'(s_cnt), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_dout", i),  32'(s_dout), 32'(tbl[i].dout));
            chk($sformatf("vec%0d_flags", i), {s_full, s_empty, s_ovf, s_unf},
                {tbl[i].full, tbl[i].empty, tbl[i].ovf, tbl[i].unf});
        end

        // Full FIFO with simultaneous read and write.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b0, 1'b1, 8'hAA, 1'b1);
        chk("fullrw_count", 32'(s_cnt), 8);
        chk("fullrw_ovf",   32'(s_ovf), 0);
        chk("fullrw_dout",  32'(s_dout), 32'h40);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("fullrw_last", 32'(s_dout), 32'hAA);

        // Pointer wrap.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("wrap_pre", 32'(s_dout), 32'(i));
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        chk("wrap_count", 32'(s_cnt), 7);
        begin
            logic [7:0] order [7] = '{8'h05, 8'h06, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
            for (int i = 0; i < 7; i++) begin
                step(1'b0, 1'b0, 8'h00, 1'b1);
                chk("wrap_order", 32'(s_dout), 32'(order[i]));
            end
        end

        // FWFT: written word appears without a read.
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        chk("fwft_show", 32'(f_dout), 32'h3C);
        chk("fwft_nonempty", 32'(f_empty), 0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("fwft_pop_empty", 32'(f_empty), 1);

        // Flush beats a concurrent write and clears sticky flags.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("preflush_count", 32'(s_cnt), 5);
        chk("preflush_ovf",   32'(s_ovf), 1);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        chk("flush_count", 32'(s_cnt), 0);
        chk("flush_flags", {s_empty, s_ovf, s_unf}, 32'b100);
        chk("flush_dout",  32'(s_dout), 0);

        // Async reset mid-burst.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h50 + i), (i == 3));
        @(negedge clk);
        wr_en = 1'b1; data_in = 8'h99; rd_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_count", 32'(s_cnt), 0);
        chk("arst_flags", {s_full, s_empty, s_af, s_ae, s_ovf, s_unf}, 32'b010100);
        chk("arst_dout",  32'(s_dout), 0);
        model_reset();
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Randomised traffic with phases biased toward full and toward empty.
        for (int i = 0; i < 400; i++) begin
            int pw = ((i / 40) % 2 == 0) ? 75 : 25;
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < pw,
                 8'($urandom),
                 $urandom_range(0, 99) < (100 - pw));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
